// File: rtl/templatized_alu_pkg.sv
// Shared opcode/state encodings and helpers for the pipelined templatized ALU.
// Imported by the top level and the iterative multiplier.
package templatized_alu_pkg;

   localparam int ALU_OP_W = 4;
   localparam int NUM_OPS  = 9;

   typedef enum logic [ALU_OP_W-1:0] {
      OP_ADD = 4'd0,
      OP_SUB = 4'd1,
      OP_AND = 4'd2,
      OP_OR  = 4'd3,
      OP_XOR = 4'd4,
      OP_SLL = 4'd5,
      OP_SRL = 4'd6,
      OP_SRA = 4'd7,
      OP_MUL = 4'd8
   } alu_op_e;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      BUSY = 1'b1
   } alu_state_e;

   function automatic logic is_legal_op(input logic [ALU_OP_W-1:0] op_i);
      return (int'(op_i) < NUM_OPS);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier: one partial product per cycle, WIDTH steps,
// returning the low WIDTH bits of the unsigned product.
module alu_mul_iter
   import templatized_alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CW = $clog2(WIDTH) + 1;

   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] acc_q;
   logic [WIDTH-1:0] acc_d;
   logic [CW-1:0]    cnt_q;
   logic             busy_q;
   logic             last_s;

   // Partial-product accumulate; only the low WIDTH bits are ever needed
   always_comb begin
      acc_d = acc_q;
      if (b_q[0]) begin
         acc_d = acc_q + a_q;
      end else begin
         acc_d = acc_q;
      end
   end

   assign last_s  = (cnt_q == CW'(WIDTH - 1));
   assign busy    = busy_q;
   assign done    = busy_q && last_s;
   assign product = acc_d;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q    <= {WIDTH{1'b0}};
         b_q    <= {WIDTH{1'b0}};
         acc_q  <= {WIDTH{1'b0}};
         cnt_q  <= {CW{1'b0}};
         busy_q <= 1'b0;
      end else if (start) begin
         a_q    <= A;
         b_q    <= B;
         acc_q  <= {WIDTH{1'b0}};
         cnt_q  <= {CW{1'b0}};
         busy_q <= 1'b1;
      end else if (busy_q) begin
         a_q    <= a_q << 1;
         b_q    <= b_q >> 1;
         acc_q  <= acc_d;
         cnt_q  <= cnt_q + CW'(1);
         busy_q <= !last_s;
      end
   end

endmodule

// File: rtl/templatized_alu_pipe.sv
// Handshaked ALU: single-cycle add/bool/shift groups with a registered result,
// plus an iterative multiply that holds off new requests until it completes.
module templatized_alu_pipe
   import templatized_alu_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int OP_W  = 4,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [OP_W-1:0]  op,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic [TAG_W-1:0] out_tag,
   output logic             out_zero,
   output logic             out_carry,
   output logic             out_err
);

   localparam int SHW = $clog2(WIDTH);

   alu_state_e       state_q;
   alu_op_e          op_e;
   logic             accept_s;
   logic             is_mul_s;
   logic             load_s;
   logic [SHW-1:0]   shamt_s;
   logic [WIDTH:0]   sum_s;
   logic [WIDTH:0]   dif_s;

   logic [WIDTH-1:0] alu_res_s;
   logic             alu_carry_s;
   logic             alu_err_s;

   logic [WIDTH-1:0] res_d;
   logic             zero_d;
   logic             carry_d;
   logic             err_d;
   logic [TAG_W-1:0] tag_d;

   logic             out_valid_q;
   logic [WIDTH-1:0] out_q;
   logic [TAG_W-1:0] out_tag_q;
   logic             out_zero_q;
   logic             out_carry_q;
   logic             out_err_q;
   logic [TAG_W-1:0] mul_tag_q;

   logic             mul_busy_s;
   logic             mul_done_s;
   logic [WIDTH-1:0] mul_product_s;

   assign op_e     = alu_op_e'(op);
   assign is_mul_s = (op_e == OP_MUL);
   assign in_ready = (state_q != BUSY) && !mul_busy_s && (!out_valid_q || out_ready);
   assign accept_s = in_valid && in_ready;
   assign load_s   = (accept_s && !is_mul_s) || mul_done_s;
   assign shamt_s  = B[SHW-1:0];

   // SUB as A + ~B + 1 so the carry-out directly means "no borrow"
   assign sum_s = {1'b0, A} + {1'b0, B};
   assign dif_s = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};

   alu_mul_iter #(
      .WIDTH(WIDTH)
   ) u_mul (
      .clk    (clk),
      .rst    (rst),
      .start  (accept_s && is_mul_s),
      .A      (A),
      .B      (B),
      .busy   (mul_busy_s),
      .done   (mul_done_s),
      .product(mul_product_s)
   );

   always_comb begin
      alu_res_s   = {WIDTH{1'b0}};
      alu_carry_s = 1'b0;
      alu_err_s   = 1'b0;
      if (!is_legal_op(op_e)) begin
         alu_err_s = 1'b1;
      end else begin
         case (op_e)
            OP_ADD: begin
               alu_res_s   = sum_s[WIDTH-1:0];
               alu_carry_s = sum_s[WIDTH];
            end
            OP_SUB: begin
               alu_res_s   = dif_s[WIDTH-1:0];
               alu_carry_s = dif_s[WIDTH];
            end
            OP_AND:  alu_res_s = A & B;
            OP_OR:   alu_res_s = A | B;
            OP_XOR:  alu_res_s = A ^ B;
            OP_SLL:  alu_res_s = A << shamt_s;
            OP_SRL:  alu_res_s = A >> shamt_s;
            OP_SRA:  alu_res_s = $signed(A) >>> shamt_s;
            OP_MUL:  alu_res_s = {WIDTH{1'b0}};
            default: alu_err_s = 1'b1;
         endcase
      end
   end

   // Only one source can load per cycle: a multiply finishes only while BUSY,
   // when no new request is accepted.
   always_comb begin
      if (mul_done_s) begin
         res_d   = mul_product_s;
         carry_d = 1'b0;
         err_d   = 1'b0;
         tag_d   = mul_tag_q;
      end else begin
         res_d   = alu_res_s;
         carry_d = alu_carry_s;
         err_d   = alu_err_s;
         tag_d   = in_tag;
      end
      zero_d = (res_d == {WIDTH{1'b0}});
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         mul_tag_q   <= {TAG_W{1'b0}};
         out_valid_q <= 1'b0;
         out_q       <= {WIDTH{1'b0}};
         out_tag_q   <= {TAG_W{1'b0}};
         out_zero_q  <= 1'b0;
         out_carry_q <= 1'b0;
         out_err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept_s && is_mul_s) begin
                  state_q   <= BUSY;
                  mul_tag_q <= in_tag;
               end
            end
            BUSY: begin
               if (mul_done_s) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase

         if (load_s) begin
            out_valid_q <= 1'b1;
            out_q       <= res_d;
            out_tag_q   <= tag_d;
            out_zero_q  <= zero_d;
            out_carry_q <= carry_d;
            out_err_q   <= err_d;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
         end
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign out_tag   = out_tag_q;
   assign out_zero  = out_zero_q;
   assign out_carry = out_carry_q;
   assign out_err   = out_err_q;

endmodule

// File: tb/tb_templatized_alu_pipe.sv
// Directed and randomized bench for templatized_alu_pipe (WIDTH=16) against a
// transaction-level reference model.
module tb_templatized_alu_pipe;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] A;
   logic [15:0] B;
   logic [3:0]  op;
   logic [3:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] res_o;
   logic [3:0]  out_tag;
   logic        out_zero;
   logic        out_carry;
   logic        out_err;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [15:0] res;
      logic        zero;
      logic        carry;
      logic        err;
   } exp_t;

   templatized_alu_pipe #(.WIDTH(16), .OP_W(4), .TAG_W(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .op       (op),
      .in_tag   (in_tag),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out      (res_o),
      .out_tag  (out_tag),
      .out_zero (out_zero),
      .out_carry(out_carry),
      .out_err  (out_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t ref_alu(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b);
      exp_t        r;
      int unsigned n;
      int unsigned ua;
      int unsigned ub;
      int unsigned p;
      n  = int'(b) % 16;
      ua = int'(a);
      ub = int'(b);
      r.res = 16'h0; r.carry = 1'b0; r.err = 1'b0;
      case (o)
         4'd0: begin p = ua + ub; r.res = p[15:0]; r.carry = (p > 32'd65535); end
         4'd1: begin r.res = a - b; r.carry = (a >= b); end
         4'd2: r.res = a & b;
         4'd3: r.res = a | b;
         4'd4: r.res = a ^ b;
         4'd5: r.res = a << n;
         4'd6: r.res = a >> n;
         4'd7: r.res = a[15] ? ~((~a) >> n) : (a >> n);
         4'd8: begin p = ua * ub; r.res = p[15:0]; end
         default: r.err = 1'b1;
      endcase
      r.zero = (r.res == 16'h0);
      return r;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_res(input string tag, input logic [3:0] o, input logic [15:0] a,
                            input logic [15:0] b, input logic [3:0] t);
      exp_t e;
      e = ref_alu(o, a, b);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_out"},   32'(res_o),     32'(e.res));
      check({tag, "_zero"},  32'(out_zero),  32'(e.zero));
      check({tag, "_carry"}, 32'(out_carry), 32'(e.carry));
      check({tag, "_err"},   32'(out_err),   32'(e.err));
      check({tag, "_tag"},   32'(out_tag),   32'(t));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] o, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t);
      op = o; A = a; B = b; in_tag = t;
   endtask

   initial begin
      logic        m_valid;
      exp_t        m_res;
      logic [3:0]  m_tag;
      int          m_cnt;
      exp_t        m_pend;
      logic [3:0]  m_ptag;
      logic        exp_ready;
      logic        acc;
      logic        acc_prev;
      logic        ld;
      int          r;

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      drive(4'd0, 16'h0, 16'h0, 4'd0);
      tick(); tick();
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_out",   32'(res_o),     32'd0);
      check("rst_tag",   32'(out_tag),   32'd0);
      check("rst_flags", 32'({out_zero, out_carry, out_err}), 32'd0);
      @(negedge clk); rst = 1'b0; #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);

      // ADD wrap-around with carry
      drive(4'd0, 16'hFFFF, 16'h0001, 4'd3); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      check_res("add_wrap", 4'd0, 16'hFFFF, 16'h0001, 4'd3);
      check("add_lit", 32'({res_o, out_zero, out_carry}), {14'd0, 16'h0000, 2'b11});

      // SUB then SRA back-to-back
      drive(4'd1, 16'h0005, 16'h0007, 4'd1); in_valid = 1'b1;
      tick();
      check_res("sub", 4'd1, 16'h0005, 16'h0007, 4'd1);
      check("sub_lit", 32'(res_o), 32'h0000_FFFE);
      check("b2b_ready", 32'(in_ready), 32'd1);
      drive(4'd7, 16'h8000, 16'h0013, 4'd2);
      tick(); in_valid = 1'b0;
      check_res("sra", 4'd7, 16'h8000, 16'h0013, 4'd2);
      check("sra_lit", 32'(res_o), 32'h0000_F000);

      // MUL with a follow-up request held during BUSY
      drive(4'd8, 16'h0123, 16'h0010, 4'd5); in_valid = 1'b1;
      tick();
      drive(4'd0, 16'h0007, 16'h0009, 4'd6);
      for (int k = 0; k < 16; k++) begin
         check("mul_busy_ready", 32'(in_ready), 32'd0);
         check("mul_busy_valid", 32'(out_valid), 32'd0);
         tick();
      end
      check_res("mul", 4'd8, 16'h0123, 16'h0010, 4'd5);
      check("mul_lit", 32'(res_o), 32'h0000_1230);
      check("mul_done_ready", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      check_res("add_after_mul", 4'd0, 16'h0007, 16'h0009, 4'd6);

      // Backpressure on an AND result, then XOR replaces it on the consume edge
      drive(4'd2, 16'hA5A5, 16'h0FF0, 4'd7); in_valid = 1'b1;
      tick();
      out_ready = 1'b0;
      drive(4'd4, 16'h1234, 16'h00FF, 4'd8);
      #1;
      for (int k = 0; k < 5; k++) begin
         check_res("bp_hold", 4'd2, 16'hA5A5, 16'h0FF0, 4'd7);
         check("bp_ready", 32'(in_ready), 32'd0);
         tick();
      end
      out_ready = 1'b1; #1;
      check("bp_release_ready", 32'(in_ready), 32'd1);
      tick(); in_valid = 1'b0;
      check_res("bp_xor", 4'd4, 16'h1234, 16'h00FF, 4'd8);
      tick();
      check("bp_no_dup", 32'(out_valid), 32'd0);

      // Illegal opcode
      drive(4'hC, 16'h1234, 16'h5678, 4'd9); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      check_res("illegal", 4'hC, 16'h1234, 16'h5678, 4'd9);
      check("illegal_lit", 32'({res_o, out_err, out_zero}), {14'd0, 16'h0000, 2'b11});

      // Reset in the middle of a multiply
      drive(4'd0, 16'h1111, 16'h2222, 4'd10); in_valid = 1'b1;
      tick();
      drive(4'd8, 16'h0007, 16'h0003, 4'd11);
      tick(); in_valid = 1'b0;
      repeat (6) tick();
      #2 rst = 1'b1; #1;
      check("mrst_valid", 32'(out_valid), 32'd0);
      check("mrst_out",   32'(res_o),     32'd0);
      check("mrst_tag",   32'(out_tag),   32'd0);
      check("mrst_flags", 32'({out_zero, out_carry, out_err}), 32'd0);
      tick();
      @(negedge clk); rst = 1'b0;
      tick();
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      drive(4'd0, 16'h0002, 16'h0003, 4'd4); in_valid = 1'b1;
      tick(); in_valid = 1'b0;
      check_res("post_rst_add", 4'd0, 16'h0002, 16'h0003, 4'd4);
      check("post_rst_lit", 32'(res_o), 32'd5);
      for (int k = 0; k < 20; k++) begin
         tick();
         check("no_stale_mul", 32'(out_valid), 32'd0);
      end

      // Randomized traffic against a cycle-level transaction model
      m_valid = 1'b0; m_cnt = 0; acc_prev = 1'b0;
      m_res = ref_alu(4'd0, 16'h0, 16'h0); m_pend = m_res; m_tag = 4'd0; m_ptag = 4'd0;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!in_valid || acc_prev) begin
            in_valid = ($urandom_range(0, 3) != 0);
            r = $urandom_range(0, 19);
            op = (r < 16) ? 4'(r) : 4'd8;
            A = 16'($urandom); B = 16'($urandom); in_tag = 4'($urandom);
         end
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         exp_ready = (m_cnt == 0) && (!m_valid || out_ready);
         check("rnd_in_ready", 32'(in_ready), 32'(exp_ready));
         acc = in_valid && exp_ready;
         tick();
         ld = 1'b0;
         if (m_cnt > 0) begin
            m_cnt--;
            if (m_cnt == 0) begin
               ld = 1'b1; m_res = m_pend; m_tag = m_ptag;
            end
         end else if (acc) begin
            if (op == 4'd8) begin
               m_cnt = 16; m_pend = ref_alu(op, A, B); m_ptag = in_tag;
            end else begin
               ld = 1'b1; m_res = ref_alu(op, A, B); m_tag = in_tag;
            end
         end
         if (ld) m_valid = 1'b1;
         else if (out_ready) m_valid = 1'b0;
         check("rnd_valid", 32'(out_valid), 32'(m_valid));
         if (m_valid) begin
            check("rnd_out", 32'({out_tag, out_zero, out_carry, out_err, res_o}),
                  32'({m_tag, m_res.zero, m_res.carry, m_res.err, m_res.res}));
         end
         acc_prev = acc;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/templatized_alu_pipe.md
Name: templatized_alu_pipe

Overview:
Parametrised successor to the single-cycle templatized ALU. Adds a valid/ready handshake on input and output, a registered result with status flags, and a pass-through request tag. Adds an iterative multi-cycle multiply group alongside the single-cycle add, bool and shift groups. Sits between the operand-issue stage and the writeback stage; one operation is in flight at a time.

Parameters:
WIDTH, 16, operand/result width in bits; must be >= 4 and a power of two.
OP_W, 4, opcode width; encodings come from templatized_alu_pkg.
TAG_W, 4, width of the request tag carried through to the result.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  request valid
in_ready  out  1  block can accept a request this cycle
A  in  WIDTH  operand A
B  in  WIDTH  operand B
op  in  OP_W  opcode
in_tag  in  TAG_W  request tag
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result this cycle
out  out  WIDTH  result
out_tag  out  TAG_W  tag of the request that produced out
out_zero  out  1  out == 0
out_carry  out  1  ADD: carry-out; SUB: no-borrow (A >= B, unsigned); all other ops: 0
out_err  out  1  illegal opcode; out = 0 when set

Behaviour:
- Opcodes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, MUL=8 (low WIDTH bits of the unsigned product). Codes 9..15 are illegal.
- Shift ops use B[$clog2(WIDTH)-1:0] as the shift amount; all higher bits of B are ignored. SRA replicates A[WIDTH-1].
- Arithmetic is modulo 2^WIDTH. Carry is taken from a WIDTH+1-bit sum. SUB is computed as A + ~B + 1.
- A request is accepted in a cycle where in_valid && in_ready. A, B, op and in_tag are sampled on that edge.
- in_ready = (state != BUSY) && (!out_valid || out_ready). The output register is therefore never overwritten before it is consumed.
- FSM states: IDLE and BUSY.
  - IDLE, accept of a non-MUL op (including an illegal op): the result, flags and tag load into the output register on the accept edge. out_valid is 1 in the next cycle (latency 1). This gives full throughput: back-to-back accepts with out_ready=1 produce a result every cycle.
  - IDLE, accept of MUL: go to BUSY and load the multiplier. The multiplier does one shift-add step per cycle for WIDTH steps. On the edge completing step WIDTH, load the output register, set out_valid and return to IDLE. out_valid first rises WIDTH cycles after the accept edge. in_ready=0 throughout BUSY.
- Output hold: while out_valid && !out_ready, out, out_tag and all flags are stable.
- out_valid clears on an edge with out_ready=1 unless a new result loads on that same edge. Simultaneous consume and load (accept with out_valid && out_ready) is legal; the new result replaces the old one.
- out_zero and out_err are registered with out. out_carry=0 for MUL and logic ops.
- Reset (asserted at any time, including mid-MUL): the FSM goes to IDLE and the multiplier is abandoned. out_valid=0, out=0, out_tag=0, out_zero=0, out_carry=0, out_err=0. in_ready=1 from the first cycle after rst deasserts.
- in_valid while in_ready=0 is ignored. The requester must hold its request until accepted.

Decomposition:
- templatized_alu_pkg holds:
  - alu_op_e: the opcode enum above, OP_W bits.
  - alu_state_e: IDLE, BUSY.
  - Constants NUM_OPS=9 and a function is_legal_op.
- Sub-module alu_mul_iter (parameter WIDTH):
  - Inputs: clk, rst, start, A, B.
  - Outputs: busy, done (1-cycle pulse), product[WIDTH-1:0].
  - Contains the shift-add datapath and a $clog2(WIDTH)+1-bit step counter.
- The single-cycle groups are computed combinationally in the top level from the sampled inputs.

Test Plan (WIDTH=16):
- ADD A=0xFFFF, B=0x0001, tag=3, out_ready=1 -> one cycle later: out_valid=1, out=0x0000, out_zero=1, out_carry=1, out_tag=3.
- SUB 0x0005-0x0007, then SRA A=0x8000, B=0x0013, issued back-to-back -> 0xFFFE with carry=0; then 0xF000 (shift amount 3). Results arrive on consecutive cycles.
- MUL A=0x0123, B=0x0010 -> in_ready=0 for 16 cycles; out=0x1230 with out_valid rising 16 cycles after accept; the next request is accepted only after completion.
- Backpressure: out_ready=0 for 5 cycles after an AND result -> out and flags stable, in_ready=0; out_ready=1 with a new XOR accepted on the same edge -> XOR result replaces the AND result, with no gap and no duplicate.
- Illegal op=0xC, A=0x1234 -> out=0, out_err=1, out_zero=1.
- rst asserted at step 7 of a MUL -> out_valid=0 and all outputs 0 immediately. After rst deasserts: in_ready=1, and a fresh ADD 2+3 returns 5 with no stale MUL result appearing.
